// File: rtl/nrzi_decoder_if.sv
// Word-side handshake bundle for nrzi_decoder.
//   out_data  : decoded word, LSB = first received bit
//   out_valid : out_data holds an unconsumed word
//   out_ready : consumer accepts the word this cycle
// master = decoder (producer), slave = word consumer.
interface nrzi_decoder_if #(
  parameter int unsigned BIT_LEN = 8
);
  logic [BIT_LEN-1:0] out_data;
  logic               out_valid;
  logic               out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/nrzi_decoder.sv
// NRZI-M line decoder and LSB-first deserializer with a one-word holding
// register on a valid/ready output.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   line_in    : sampled NRZI line level
//   in_valid   : line_in carries a new bit this cycle
//   clr        : synchronous clear of framing state (partial word, bit count,
//                line history, overflow); the holding register is untouched
//   bus        : master side of nrzi_decoder_if (out_data/out_valid/out_ready)
//   overflow   : sticky, a completed word was dropped while the holder was full
//   stuff_err  : one-cycle pulse on a bit-stuffing violation
// Optional feature: define NRZI_DESTUFF_EN to remove a stuff bit after every
// run of six decoded 1s; without it stuff_err is tied to 0.
module nrzi_decoder #(
  parameter int unsigned BIT_LEN = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           line_in,
  input  logic           in_valid,
  input  logic           clr,
  nrzi_decoder_if.master bus,
  output logic           overflow,
  output logic           stuff_err
);

  localparam int unsigned CW = (BIT_LEN > 1) ? $clog2(BIT_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_LEN - 1);

  logic               prev_level;
  logic [BIT_LEN-1:0] shift_q;
  logic [CW-1:0]      bit_cnt;

  logic               bit_d;
  logic               take;
  logic               accept;
  logic               complete;
  logic               drain;
  logic               load;
  logic [BIT_LEN-1:0] word;

`ifdef NRZI_DESTUFF_EN
  logic [2:0] ones_cnt;
  logic       stuff_slot;
  logic       stuff_bad;
`endif

  always_comb begin
    bit_d = line_in ^ prev_level;
    take  = in_valid & ~clr;
`ifdef NRZI_DESTUFF_EN
    stuff_slot = (ones_cnt == 3'd6);
    accept     = take & ~stuff_slot;
    stuff_bad  = take & stuff_slot & bit_d;
`else
    accept     = take;
`endif
    // Shift register with the current bit merged in; this is the finished
    // word when the last position is being written.
    word          = shift_q;
    word[bit_cnt] = bit_d;
    complete      = accept && (bit_cnt == LAST);
    drain         = bus.out_valid & bus.out_ready;
    load          = complete & (~bus.out_valid | drain);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_level    <= 1'b0;
      shift_q       <= '0;
      bit_cnt       <= '0;
      overflow      <= 1'b0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
`ifdef NRZI_DESTUFF_EN
      ones_cnt      <= '0;
      stuff_err     <= 1'b0;
`endif
    end else begin
      if (clr) begin
        prev_level <= 1'b0;
        shift_q    <= '0;
        bit_cnt    <= '0;
        overflow   <= 1'b0;
`ifdef NRZI_DESTUFF_EN
        ones_cnt   <= '0;
`endif
      end else if (in_valid) begin
        prev_level <= line_in;
        if (accept) begin
          if (complete) begin
            bit_cnt <= '0;
            shift_q <= '0;
            if (!load) overflow <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            shift_q <= word;
          end
`ifdef NRZI_DESTUFF_EN
          ones_cnt <= bit_d ? ones_cnt + 3'd1 : 3'd0;
        end else begin
          // Stuff slot: the bit is dropped; a 1 here aborts the partial word.
          ones_cnt <= '0;
          if (bit_d) begin
            bit_cnt <= '0;
            shift_q <= '0;
          end
`endif
        end
      end

      if (load) begin
        bus.out_data  <= word;
        bus.out_valid <= 1'b1;
      end else if (drain) begin
        bus.out_valid <= 1'b0;
      end

`ifdef NRZI_DESTUFF_EN
      stuff_err <= stuff_bad;
`endif
    end
  end

`ifndef NRZI_DESTUFF_EN
  assign stuff_err = 1'b0;
`endif

endmodule

// File: tb/tb_nrzi_decoder.sv
module tb_nrzi_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line_in = 1'b0;
  logic in_valid = 1'b0;
  logic clr = 1'b0;
  logic overflow;
  logic stuff_err;

  nrzi_decoder_if #(.BIT_LEN(8)) bus ();

  nrzi_decoder #(.BIT_LEN(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_in   (line_in),
    .in_valid  (in_valid),
    .clr       (clr),
    .bus       (bus.master),
    .overflow  (overflow),
    .stuff_err (stuff_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic level = 1'b0;        // bench model of the transmitted line level
  logic [7:0] q[$];          // expected words, in delivery order

`ifdef NRZI_DESTUFF_EN
  localparam logic [7:0] WFULL = 8'h77;
`else
  localparam logic [7:0] WFULL = 8'hFF;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every handshake transfer must match the oldest expected word.
  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got 0x%0h expected none", bus.out_data);
      end else begin
        e = q.pop_front();
        check("scoreboard", {24'd0, bus.out_data}, {24'd0, e});
      end
    end
  end

  task automatic send_level(input logic l);
    line_in  = l;
    level    = l;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    send_level(level ^ b);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr   = 1'b0;
    level = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", q.size(), 0);
  endtask

  typedef struct {
    bit         raw;   // 1: stim is the line level sequence; 0: stim is the word to encode
    logic [7:0] stim;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // line 1,1,0,0,0,1,1,0 (first level in bit 0) decodes to 0xA5
    vecs[0] = '{raw: 1'b1, stim: 8'b0110_0011, exp: 8'hA5};
    vecs[1] = '{raw: 1'b0, stim: 8'h00, exp: 8'h00};
    vecs[2] = '{raw: 1'b0, stim: 8'hE7, exp: 8'hE7};
    vecs[3] = '{raw: 1'b0, stim: 8'h5A, exp: 8'h5A};
    vecs[4] = '{raw: 1'b0, stim: 8'h81, exp: 8'h81};
    vecs[5] = '{raw: 1'b0, stim: 8'h3C, exp: 8'h3C};

    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_stuff_err", stuff_err, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven decode, consumer always ready
    for (int v = 0; v < 6; v++) begin
      q.push_back(vecs[v].exp);
      if (vecs[v].raw) for (int i = 0; i < 8; i++) send_level(vecs[v].stim[i]);
      else send_word(vecs[v].stim);
      check("vec_valid", bus.out_valid, 1);
      check("vec_data", bus.out_data, vecs[v].exp);
    end
    wait_empty();
    check("vec_overflow", overflow, 0);

    // Backpressure: second word is dropped while the first is held
    bus.out_ready = 1'b0;
    q.push_back(8'hA5);
    send_word(8'hA5);
    send_word(8'h00);
    check("bp_valid", bus.out_valid, 1);
    check("bp_data", bus.out_data, 8'hA5);
    check("bp_overflow", overflow, 1);
    bus.out_ready = 1'b1;
    wait_empty();
    check("bp_valid_fall", bus.out_valid, 0);
    check("bp_overflow_sticky", overflow, 1);
    pulse_clr();
    check("clr_overflow", overflow, 0);

    // Drain and load in the same cycle
    bus.out_ready = 1'b0;
    q.push_back(8'h12);
    q.push_back(WFULL);
    send_word(8'h12);
    check("dl_first", bus.out_data, 8'h12);
    for (int i = 0; i < 7; i++) send_bit(WFULL[i]);
    bus.out_ready = 1'b1;
    send_bit(WFULL[7]);
    check("dl_valid", bus.out_valid, 1);
    check("dl_data", bus.out_data, WFULL);
    check("dl_overflow", overflow, 0);
    check("dl_stuff_err", stuff_err, 0);
    wait_empty();
    check("dl_valid_fall", bus.out_valid, 0);

    // clr mid-word, coinciding with a strobe
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    clr = 1'b1;
    line_in = ~level;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    in_valid = 1'b0;
    level = 1'b0;
    q.push_back(8'h3C);
    send_word(8'h3C);
    check("clr_valid", bus.out_valid, 1);
    check("clr_data", bus.out_data, 8'h3C);
    wait_empty();

    // Asynchronous reset mid-word with a pending word
    bus.out_ready = 1'b0;
    send_word(8'h5A);
    check("ar_pending", bus.out_data, 8'h5A);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", bus.out_valid, 0);
    check("ar_data", bus.out_data, 0);
    check("ar_overflow", overflow, 0);
    #2 rst_n = 1'b1;
    level = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    q.push_back(8'hC3);
    send_word(8'hC3);
    check("ar_fresh_valid", bus.out_valid, 1);
    check("ar_fresh_data", bus.out_data, 8'hC3);
    wait_empty();

`ifdef NRZI_DESTUFF_EN
    // Stuff bit 0 removed
    pulse_clr();
    q.push_back(8'hBF);
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    send_bit(1'b0);
    check("ds_no_err", stuff_err, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    check("ds_valid", bus.out_valid, 1);
    check("ds_data", bus.out_data, 8'hBF);
    wait_empty();
    // Stuff bit 1: error pulse, partial word discarded
    pulse_clr();
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    send_bit(1'b1);
    check("se_pulse", stuff_err, 1);
    check("se_no_word", bus.out_valid, 0);
    @(posedge clk);
    #1;
    check("se_pulse_end", stuff_err, 0);
    q.push_back(8'h96);
    send_word(8'h96);
    check("se_fresh_data", bus.out_data, 8'h96);
    wait_empty();
`else
    // Long run of 1s is passed through untouched
    pulse_clr();
    q.push_back(8'hFF);
    q.push_back(8'h7F);
    send_word(8'hFF);
    send_word(8'h7F);
    check("ns_stuff_err", stuff_err, 0);
    check("ns_data", bus.out_data, 8'h7F);
    wait_empty();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nrzi_decoder.md
Name: nrzi_decoder

Overview:
- Receive-side counterpart of the library's inverting/encoding logic.
- Takes a sampled NRZI (NRZI-M) line and decodes each bit: a transition is 1, no transition is 0.
- Deserializes the decoded bits LSB-first into BIT_LEN-bit words.
- Presents each word on a valid/ready output interface with a one-word holding register.
- Sits between a line sampler (bit strobe) and any word-wide consumer in the logic library demos.

Parameters:
- BIT_LEN, 8, width of the output word in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- line_in  input  1  sampled NRZI line level
- in_valid  input  1  line_in holds a new bit this cycle (one bit per strobe)
- clr  input  1  synchronous clear of the framing state (partial word, bit count, line history, overflow)
- out_data  output  BIT_LEN  decoded word, LSB = first received bit
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  consumer accepts the word this cycle
- overflow  output  1  sticky: a completed word was dropped
- stuff_err  output  1  one-cycle pulse on a bit-stuffing violation (see Optional Feature)

Behaviour:
- Reset (rst_n=0, async) clears these registers:
  - prev_level=0, shift register=0, bit_cnt=0, ones_cnt=0.
  - out_data=0, out_valid=0, overflow=0, stuff_err=0.
- Decode: on a cycle with in_valid=1:
  - bit = line_in XOR prev_level.
  - prev_level <= line_in.
  - Cycles with in_valid=0 change nothing.
- Shift: each decoded (non-discarded) bit is written to position bit_cnt; bit_cnt increments.
- Word complete when bit_cnt reaches BIT_LEN-1 and a bit is accepted. Then bit_cnt <= 0.
  - Holding register empty, or being drained this cycle (out_valid & out_ready): the word loads into out_data and out_valid=1 the next cycle. Latency is 1 clk after the strobe of the last bit.
  - Holding register full and not drained: the word is dropped, overflow <= 1 (sticky), and out_data is unchanged.
- Handshake:
  - Transfer occurs on out_valid & out_ready.
  - out_valid falls the next cycle unless a new word loads in the same cycle; in that case it stays 1 with the new data.
  - out_data is stable while out_valid=1 and out_ready=0.
  - out_ready while out_valid=0 is ignored.
- clr=1:
  - Zeroes bit_cnt, ones_cnt, the shift register, prev_level and overflow.
  - Does not touch out_data/out_valid; a pending word remains deliverable.
  - clr has priority over an in_valid bit in the same cycle, and that bit is discarded.
- Reset mid-word: the partial word is lost and no output is generated.
- Internal state: the FSM is implicit in bit_cnt (0..BIT_LEN-1) plus the holding-register full flag.

Optional Feature:
- Macro: NRZI_DESTUFF_EN.
- With the macro defined:
  - ones_cnt counts consecutive decoded 1s.
  - After 6 consecutive 1s, the next decoded bit is a stuff bit and is discarded (not shifted, bit_cnt unchanged); ones_cnt <= 0.
  - If that stuff bit is 1: stuff_err pulses high for one cycle and the partial word is discarded (bit_cnt=0, shift register=0).
  - A decoded 0 resets ones_cnt.
  - prev_level always updates on in_valid, including for stuff bits.
- Without the macro: there is no stuffing logic, every bit is shifted, and stuff_err is tied to 0.

Test Plan:
- All tests use BIT_LEN=8 after reset.
- Basic decode: line_in 1,1,0,0,0,1,1,0 on 8 consecutive in_valid cycles, out_ready=1 -> out_valid=1 one cycle after the 8th strobe, out_data=0xA5, overflow=0.
- Backpressure: decode 0xA5, then 0x00 (line held constant for 8 strobes), out_ready=0 -> out_data stays 0xA5, overflow=1. Then out_ready=1 -> transfer of 0xA5, then out_valid=0.
- Simultaneous drain/load: first word pending; out_ready=1 in the same cycle as the last bit of 0xFF -> out_valid stays 1, out_data=0xFF next cycle, overflow=0.
- clr mid-word: 4 bits received, then clr=1 coinciding with a strobe, then 8 bits encoding 0x3C -> out_data=0x3C (the partial and coincident bits are discarded).
- Async reset mid-word: rst_n low for 3 ns between clock edges after 5 bits -> all outputs 0 immediately; next 8 bits yield a fresh word.
- With NRZI_DESTUFF_EN: decoded bits 1,1,1,1,1,1,0(stuff),0,1 -> out_data=0xBF with 8 bits shifted, stuff_err=0. Replacing the stuff bit with 1 -> stuff_err pulses for one cycle and no word is output.
